// File: rtl/obi_axil_pkg.sv
// rtl/obi_axil_pkg.sv - shared types and AXI response codes for the OBI to AXI4-Lite bridge
//
// Purpose: bridge FSM state encoding, AXI4-Lite response codes and the
// helper that maps a response code onto the OBI error flag.
package obi_axil_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RESP    = 3'd5
  } bridge_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // SLVERR and DECERR both surface as an OBI bus error; OKAY and EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    logic err;
    err = 1'b0;
    case (resp)
      AXI_RESP_OKAY,   AXI_RESP_EXOKAY: err = 1'b0;
      AXI_RESP_SLVERR, AXI_RESP_DECERR: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/obi_axil_bridge.sv
// rtl/obi_axil_bridge.sv - OBI slave to AXI4-Lite master bridge, one transaction outstanding
//
// Purpose: turns cv32e40p OBI requests into single AXI4-Lite read or write
// transactions towards the BRAM slave. A new OBI grant is only given in IDLE,
// so at most one transaction is ever in flight.
//
// Ports:
//   clk_i, rst_ni              clock, synchronous active-low reset
//   obi_req_i / obi_gnt_o      OBI request / combinational grant
//   obi_addr_i, obi_we_i,
//   obi_be_i, obi_wdata_i      OBI request payload
//   obi_rvalid_o, obi_rdata_o,
//   obi_err_o                  OBI response (one-cycle rvalid pulse)
//   m_aw_*, m_w_*, m_b_*       AXI4-Lite write address / data / response
//   m_ar_*, m_r_*              AXI4-Lite read address / data
module obi_axil_bridge
  import obi_axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LOGGING    = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic                    obi_req_i,
  output logic                    obi_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
  input  logic                    obi_we_i,
  input  logic [DATA_WIDTH/8-1:0] obi_be_i,
  input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
  output logic                    obi_rvalid_o,
  output logic [DATA_WIDTH-1:0]   obi_rdata_o,
  output logic                    obi_err_o,

  output logic [ADDR_WIDTH-1:0]   m_aw_addr_o,
  output logic                    m_aw_valid_o,
  input  logic                    m_aw_ready_i,
  output logic [DATA_WIDTH-1:0]   m_w_data_o,
  output logic [DATA_WIDTH/8-1:0] m_w_strb_o,
  output logic                    m_w_valid_o,
  input  logic                    m_w_ready_i,
  input  logic [1:0]              m_b_resp_i,
  input  logic                    m_b_valid_i,
  output logic                    m_b_ready_o,
  output logic [ADDR_WIDTH-1:0]   m_ar_addr_o,
  output logic                    m_ar_valid_o,
  input  logic                    m_ar_ready_i,
  input  logic [DATA_WIDTH-1:0]   m_r_data_i,
  input  logic [1:0]              m_r_resp_i,
  input  logic                    m_r_valid_i,
  output logic                    m_r_ready_o
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  // LOGGING selects a simulation-side transfer log that lives outside this
  // synthesizable file; here only its legal range is validated.
  if (((DATA_WIDTH % 8) != 0) || (LOGGING > 1)) begin : g_param_check
    $error("obi_axil_bridge: DATA_WIDTH must be a multiple of 8 and LOGGING must be 0 or 1");
  end

  bridge_state_e           state;

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]       be_q;

  logic                    aw_valid_q;
  logic                    w_valid_q;
  logic                    aw_done;
  logic                    w_done;
  logic                    b_ready_q;
  logic                    ar_valid_q;
  logic                    r_ready_q;
  logic                    rvalid_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;

  logic                    aw_fire;
  logic                    w_fire;
  logic                    aw_done_nx;
  logic                    w_done_nx;

  assign aw_fire    = aw_valid_q & m_aw_ready_i;
  assign w_fire     = w_valid_q & m_w_ready_i;
  // A channel counts as done if it completed earlier or completes this cycle,
  // which lets AW and W finish in either order or together.
  assign aw_done_nx = aw_done | aw_fire;
  assign w_done_nx  = w_done | w_fire;

  assign obi_gnt_o    = obi_req_i & (state == IDLE);
  assign obi_rvalid_o = rvalid_q;
  assign obi_rdata_o  = rdata_q;
  assign obi_err_o    = err_q;

  assign m_aw_addr_o  = addr_q;
  assign m_aw_valid_o = aw_valid_q;
  assign m_w_data_o   = wdata_q;
  assign m_w_strb_o   = be_q;
  assign m_w_valid_o  = w_valid_q;
  assign m_b_ready_o  = b_ready_q;
  assign m_ar_addr_o  = addr_q;
  assign m_ar_valid_o = ar_valid_q;
  assign m_r_ready_o  = r_ready_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      b_ready_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rvalid_q <= 1'b0;
          if (obi_req_i) begin
            addr_q  <= obi_addr_i;
            wdata_q <= obi_wdata_i;
            be_q    <= obi_be_i;
            if (obi_we_i) begin
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
              aw_done    <= 1'b0;
              w_done     <= 1'b0;
              state      <= WR_AW_W;
            end else begin
              ar_valid_q <= 1'b1;
              state      <= RD_AR;
            end
          end
        end

        WR_AW_W: begin
          if (aw_fire) begin
            aw_valid_q <= 1'b0;
          end
          if (w_fire) begin
            w_valid_q <= 1'b0;
          end
          aw_done <= aw_done_nx;
          w_done  <= w_done_nx;
          if (aw_done_nx && w_done_nx) begin
            b_ready_q <= 1'b1;
            state     <= WR_B;
          end
        end

        WR_B: begin
          if (m_b_valid_i) begin
            b_ready_q <= 1'b0;
            err_q     <= resp_is_err(m_b_resp_i);
            rdata_q   <= '0;
            rvalid_q  <= 1'b1;
            state     <= RESP;
          end
        end

        RD_AR: begin
          if (m_ar_ready_i) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state      <= RD_R;
          end
        end

        RD_R: begin
          if (m_r_valid_i) begin
            r_ready_q <= 1'b0;
            rdata_q   <= m_r_data_i;
            err_q     <= resp_is_err(m_r_resp_i);
            rvalid_q  <= 1'b1;
            state     <= RESP;
          end
        end

        RESP: begin
          // Single-cycle response; the grant reopens only once back in IDLE.
          rvalid_q <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obi_axil_bridge.sv
// tb/tb_obi_axil_bridge.sv - self-checking bench for obi_axil_bridge with a behavioural AXI4-Lite slave
module tb_obi_axil_bridge;

  logic        clk;
  logic        rst_ni;
  logic        obi_req_i;
  logic        obi_gnt_o;
  logic [31:0] obi_addr_i;
  logic        obi_we_i;
  logic [3:0]  obi_be_i;
  logic [31:0] obi_wdata_i;
  logic        obi_rvalid_o;
  logic [31:0] obi_rdata_o;
  logic        obi_err_o;
  logic [31:0] m_aw_addr_o;
  logic        m_aw_valid_o;
  logic        m_aw_ready_i;
  logic [31:0] m_w_data_o;
  logic [3:0]  m_w_strb_o;
  logic        m_w_valid_o;
  logic        m_w_ready_i;
  logic [1:0]  m_b_resp_i;
  logic        m_b_valid_i;
  logic        m_b_ready_o;
  logic [31:0] m_ar_addr_o;
  logic        m_ar_valid_o;
  logic        m_ar_ready_i;
  logic [31:0] m_r_data_i;
  logic [1:0]  m_r_resp_i;
  logic        m_r_valid_i;
  logic        m_r_ready_o;

  obi_axil_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LOGGING(0)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .obi_req_i(obi_req_i), .obi_gnt_o(obi_gnt_o), .obi_addr_i(obi_addr_i),
    .obi_we_i(obi_we_i), .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i),
    .obi_rvalid_o(obi_rvalid_o), .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o),
    .m_aw_addr_o(m_aw_addr_o), .m_aw_valid_o(m_aw_valid_o), .m_aw_ready_i(m_aw_ready_i),
    .m_w_data_o(m_w_data_o), .m_w_strb_o(m_w_strb_o), .m_w_valid_o(m_w_valid_o),
    .m_w_ready_i(m_w_ready_i), .m_b_resp_i(m_b_resp_i), .m_b_valid_i(m_b_valid_i),
    .m_b_ready_o(m_b_ready_o), .m_ar_addr_o(m_ar_addr_o), .m_ar_valid_o(m_ar_valid_o),
    .m_ar_ready_i(m_ar_ready_i), .m_r_data_i(m_r_data_i), .m_r_resp_i(m_r_resp_i),
    .m_r_valid_i(m_r_valid_i), .m_r_ready_o(m_r_ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Slave memory (updated by AXI beats) and reference memory (updated by OBI intent).
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  // Slave configuration per transaction.
  int          cfg_addr_dly = 0;
  int          cfg_w_dly    = 0;
  int          cfg_rsp_dly  = 0;
  logic [1:0]  cfg_resp     = 2'b00;

  // Slave observations.
  int          aw_hi, w_hi, b_hs, r_hs, rv_cnt, stab_err;
  logic [31:0] cap_aw_addr, cap_w_data, cap_ar_addr;
  logic [3:0]  cap_w_strb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Behavioural AXI4-Lite slave, acting on falling edges. A handshake decided
  // at a falling edge completes on the next rising edge; the response may
  // follow no earlier than the falling edge after that.
  initial begin : slave
    int  aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit  aw_fq, w_fq, ar_fq, b_fq, r_fq, aw_got, w_got, ar_got;
    bit  p_aw_v, p_w_v, p_ar_v;
    logic [31:0] p_aw_a, p_w_d, p_ar_a;
    logic [3:0]  p_w_s;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    aw_fq = 0; w_fq = 0; ar_fq = 0; b_fq = 0; r_fq = 0; aw_got = 0; w_got = 0; ar_got = 0;
    p_aw_v = 0; p_w_v = 0; p_ar_v = 0; p_aw_a = 0; p_w_d = 0; p_ar_a = 0; p_w_s = 0;
    m_aw_ready_i = 0; m_w_ready_i = 0; m_ar_ready_i = 0;
    m_b_valid_i = 0; m_b_resp_i = 0; m_r_valid_i = 0; m_r_resp_i = 0; m_r_data_i = 0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_fq = 0; w_fq = 0; ar_fq = 0; b_fq = 0; r_fq = 0; aw_got = 0; w_got = 0; ar_got = 0;
        p_aw_v = 0; p_w_v = 0; p_ar_v = 0;
        m_aw_ready_i = 0; m_w_ready_i = 0; m_ar_ready_i = 0; m_b_valid_i = 0; m_r_valid_i = 0;
      end else begin
        if (m_aw_valid_o && p_aw_v && m_aw_addr_o !== p_aw_a) stab_err++;
        if (m_w_valid_o && p_w_v && (m_w_data_o !== p_w_d || m_w_strb_o !== p_w_s)) stab_err++;
        if (m_ar_valid_o && p_ar_v && m_ar_addr_o !== p_ar_a) stab_err++;
        p_aw_v = m_aw_valid_o; p_aw_a = m_aw_addr_o;
        p_w_v = m_w_valid_o; p_w_d = m_w_data_o; p_w_s = m_w_strb_o;
        p_ar_v = m_ar_valid_o; p_ar_a = m_ar_addr_o;
        if (obi_rvalid_o) rv_cnt++;

        if (aw_fq) begin aw_got = 1; aw_fq = 0; end
        if (w_fq)  begin w_got = 1;  w_fq = 0;  end
        if (ar_fq) begin ar_got = 1; ar_fq = 0; end

        m_aw_ready_i = 0;
        if (m_aw_valid_o) begin
          aw_hi++;
          if (aw_cnt >= cfg_addr_dly) begin
            m_aw_ready_i = 1; aw_fq = 1; cap_aw_addr = m_aw_addr_o; aw_cnt = 0;
          end else aw_cnt++;
        end else aw_cnt = 0;

        m_w_ready_i = 0;
        if (m_w_valid_o) begin
          w_hi++;
          if (w_cnt >= cfg_w_dly) begin
            m_w_ready_i = 1; w_fq = 1; cap_w_data = m_w_data_o; cap_w_strb = m_w_strb_o; w_cnt = 0;
          end else w_cnt++;
        end else w_cnt = 0;

        m_ar_ready_i = 0;
        if (m_ar_valid_o) begin
          if (ar_cnt >= cfg_addr_dly) begin
            m_ar_ready_i = 1; ar_fq = 1; cap_ar_addr = m_ar_addr_o; ar_cnt = 0;
          end else ar_cnt++;
        end else ar_cnt = 0;

        if (b_fq) begin m_b_valid_i = 0; b_fq = 0; end
        if (aw_got && w_got && !m_b_valid_i) begin
          if (b_cnt >= cfg_rsp_dly) begin m_b_valid_i = 1; m_b_resp_i = cfg_resp; end
          else b_cnt++;
        end
        if (m_b_valid_i && m_b_ready_o) begin
          b_fq = 1; b_hs++; aw_got = 0; w_got = 0; b_cnt = 0;
          for (int i = 0; i < 4; i++)
            if (cap_w_strb[i]) mem[cap_aw_addr[9:2]][8*i +: 8] = cap_w_data[8*i +: 8];
        end

        if (r_fq) begin m_r_valid_i = 0; r_fq = 0; end
        if (ar_got && !m_r_valid_i) begin
          if (r_cnt >= cfg_rsp_dly) begin
            m_r_valid_i = 1; m_r_resp_i = cfg_resp; m_r_data_i = mem[cap_ar_addr[9:2]];
          end else r_cnt++;
        end
        if (m_r_valid_i && m_r_ready_o) begin
          r_fq = 1; r_hs++; ar_got = 0; r_cnt = 0;
        end
      end
    end
  end

  // One OBI transaction, checked against the reference model.
  task automatic xfer(input bit we, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] wd, input logic [1:0] resp, input int ad,
                      input int wdl, input int rdl, output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat, n, cyc;
    cfg_addr_dly = ad; cfg_w_dly = wdl; cfg_rsp_dly = rdl; cfg_resp = resp;
    aw_hi = 0; w_hi = 0; b_hs = 0; r_hs = 0; rv_cnt = 0;
    exp_err = (resp == 2'b10) || (resp == 2'b11);
    if (we) begin
      exp_rd = 32'h0;
      for (int i = 0; i < 4; i++)
        if (be[i]) ref_mem[a[9:2]][8*i +: 8] = wd[8*i +: 8];
      exp_lat = 3 + ((ad > wdl) ? ad : wdl) + rdl;
    end else begin
      exp_rd  = ref_mem[a[9:2]];
      exp_lat = 3 + ad + rdl;
    end
    rd = 32'h0;
    obi_req_i = 1; obi_we_i = we; obi_addr_i = a; obi_be_i = be; obi_wdata_i = wd;
    #1;
    n = 0;
    while (!obi_gnt_o && n < 20) begin tick(); n++; end
    chk("grant", {63'h0, obi_gnt_o}, 64'h1);
    if (!obi_gnt_o) begin obi_req_i = 0; return; end
    cyc = 0;
    do begin
      tick();
      if (cyc == 0) obi_req_i = 0;
      cyc++;
    end while (!obi_rvalid_o && cyc < 60);
    chk("rvalid_seen", {63'h0, obi_rvalid_o}, 64'h1);
    chk("latency", 64'(cyc), 64'(exp_lat));
    chk("rdata", {32'h0, obi_rdata_o}, {32'h0, exp_rd});
    chk("err", {63'h0, obi_err_o}, {63'h0, exp_err});
    if (we) begin
      chk("aw_addr", {32'h0, cap_aw_addr}, {32'h0, a});
      chk("w_data", {32'h0, cap_w_data}, {32'h0, wd});
      chk("w_strb", {60'h0, cap_w_strb}, {60'h0, be});
      chk("aw_valid_cycles", 64'(aw_hi), 64'(ad + 1));
      chk("w_valid_cycles", 64'(w_hi), 64'(wdl + 1));
      chk("b_beats", 64'(b_hs), 64'h1);
    end else begin
      chk("ar_addr", {32'h0, cap_ar_addr}, {32'h0, a});
      chk("r_beats", 64'(r_hs), 64'h1);
    end
    rd = obi_rdata_o;
    tick();
    chk("rvalid_one_cycle", {63'h0, obi_rvalid_o}, 64'h0);
    chk("rvalid_count", 64'(rv_cnt), 64'h1);
  endtask

  initial begin : main
    logic [31:0] rd;
    logic [31:0] q_exp[$];
    logic [31:0] addrs[4];
    int          granted, popped, viol, n;
    bit          adv;

    rst_ni = 0; obi_req_i = 0; obi_we_i = 0; obi_addr_i = 0; obi_be_i = 0; obi_wdata_i = 0;
    aw_hi = 0; w_hi = 0; b_hs = 0; r_hs = 0; rv_cnt = 0; stab_err = 0;
    cap_aw_addr = 0; cap_w_data = 0; cap_ar_addr = 0; cap_w_strb = 0;
    for (int i = 0; i < 256; i++) begin
      rd = $urandom;
      mem[i] = rd;
      ref_mem[i] = rd;
    end
    mem[8'h40] = 32'hDEADBEEF;
    ref_mem[8'h40] = 32'hDEADBEEF;
    repeat (3) tick();

    // Reset state.
    chk("rst_gnt", {63'h0, obi_gnt_o}, 64'h0);
    chk("rst_rvalid", {63'h0, obi_rvalid_o}, 64'h0);
    chk("rst_rdata", {32'h0, obi_rdata_o}, 64'h0);
    chk("rst_err", {63'h0, obi_err_o}, 64'h0);
    chk("rst_valids", {59'h0, m_aw_valid_o, m_w_valid_o, m_ar_valid_o, m_b_ready_o, m_r_ready_o}, 64'h0);
    chk("rst_payload", {m_aw_addr_o, m_w_data_o}, 64'h0);
    chk("rst_strb", {60'h0, m_w_strb_o}, 64'h0);
    rst_ni = 1;
    tick();

    // Zero-wait read of 0xDEADBEEF at 0x100.
    xfer(0, 32'h100, 4'hF, 32'h0, 2'b00, 0, 0, 0, rd);
    // Partial write and read-back.
    xfer(1, 32'h104, 4'b0011, 32'h12345678, 2'b00, 0, 0, 0, rd);
    xfer(0, 32'h104, 4'hF, 32'h0, 2'b00, 0, 0, 0, rd);
    chk("readback_low_half", {48'h0, rd[15:0]}, 64'h5678);
    // AW held for 3 cycles, W immediate.
    xfer(1, 32'h208, 4'hF, 32'hCAFEF00D, 2'b00, 2, 0, 0, rd);
    // W delayed beyond AW, slow B.
    xfer(1, 32'h20C, 4'b1010, 32'hA5A55A5A, 2'b01, 0, 3, 2, rd);

    // Back-to-back reads with req held high.
    for (int k = 0; k < 4; k++) addrs[k] = $urandom_range(0, 255) * 4;
    cfg_addr_dly = 0; cfg_w_dly = 0; cfg_rsp_dly = 0; cfg_resp = 2'b00; rv_cnt = 0;
    granted = 0; popped = 0; viol = 0; adv = 0;
    obi_we_i = 0; obi_addr_i = addrs[0]; obi_req_i = 1;
    #1;
    for (int t = 0; t < 100 && popped < 4; t++) begin
      if (obi_rvalid_o) begin
        if (q_exp.size() == 0) viol++;
        else chk("b2b_rdata", {32'h0, obi_rdata_o}, {32'h0, q_exp.pop_front()});
        popped++;
        if (obi_gnt_o) viol++;
      end
      if (obi_gnt_o) begin
        if (granted != popped) viol++;
        q_exp.push_back(ref_mem[obi_addr_i[9:2]]);
        granted++;
        adv = 1;
      end
      tick();
      if (adv) begin
        adv = 0;
        if (granted < 4) obi_addr_i = addrs[granted];
        else obi_req_i = 0;
        #1;
      end
    end
    obi_req_i = 0;
    chk("b2b_grants", 64'(granted), 64'h4);
    chk("b2b_responses", 64'(popped), 64'h4);
    chk("b2b_rvalid_count", 64'(rv_cnt), 64'h4);
    chk("b2b_overlap", 64'(viol), 64'h0);
    tick();

    // Error responses.
    xfer(0, 32'h010, 4'hF, 32'h0, 2'b10, 0, 0, 0, rd);
    xfer(0, 32'h014, 4'hF, 32'h0, 2'b00, 0, 0, 0, rd);
    xfer(1, 32'h018, 4'hF, 32'h11223344, 2'b11, 1, 1, 1, rd);
    xfer(0, 32'h01C, 4'hF, 32'h0, 2'b01, 0, 0, 0, rd);

    // Reset while waiting in WR_B: transaction abandoned, no response.
    cfg_addr_dly = 0; cfg_w_dly = 0; cfg_rsp_dly = 20; cfg_resp = 2'b00; rv_cnt = 0;
    obi_req_i = 1; obi_we_i = 1; obi_addr_i = 32'h300; obi_be_i = 4'hF; obi_wdata_i = 32'h0BADF00D;
    #1;
    chk("rst_test_grant", {63'h0, obi_gnt_o}, 64'h1);
    tick();
    obi_req_i = 0;
    n = 0;
    while (!m_b_ready_o && n < 20) begin tick(); n++; end
    chk("rst_test_in_wr_b", {63'h0, m_b_ready_o}, 64'h1);
    rst_ni = 0;
    tick();
    rst_ni = 1;
    chk("rst_mid_valids", {59'h0, m_aw_valid_o, m_w_valid_o, m_ar_valid_o, m_b_ready_o, m_r_ready_o}, 64'h0);
    chk("rst_mid_rvalid", {63'h0, obi_rvalid_o}, 64'h0);
    cfg_rsp_dly = 0;
    repeat (10) tick();
    chk("rst_mid_no_rvalid", 64'(rv_cnt), 64'h0);
    obi_we_i = 0; obi_req_i = 1;
    #1;
    chk("rst_mid_idle", {63'h0, obi_gnt_o}, 64'h1);
    obi_req_i = 0;
    #1;
    tick();

    // Randomized transactions against the reference model.
    for (int k = 0; k < 24; k++) begin
      logic        we;
      logic [31:0] a, wd;
      logic [3:0]  be;
      logic [1:0]  resp;
      we   = $urandom_range(0, 1);
      a    = {$urandom_range(0, 15), 18'h0, 8'($urandom_range(0, 255)), 2'b00};
      be   = 4'($urandom_range(1, 15));
      wd   = $urandom;
      resp = 2'($urandom_range(0, 3));
      xfer(we, a, be, wd, resp, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), rd);
    end

    chk("payload_stable", 64'(stab_err), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
